// File: rtl/uart_pkg.sv
// UART frame definitions shared by the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE      = 3'd0,
    s_START     = 3'd1,
    s_DATA      = 3'd2,
    s_STOP      = 3'd3,
    s_CLEANUP   = 3'd4,
    s_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

endpackage

// File: rtl/receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver: 8N1 deserializer with mid-bit sampling, one-cycle byte strobe
// and a framing-error strobe; a held-low break is absorbed until the line idles.
module receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Rx_Serial_in,
  output logic       Rx_DV_out,
  output logic [7:0] Rx_Byte_out,
  output logic       Rx_Active_out,
  output logic       Rx_Frame_Err_out
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             active_q, active_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (Rx_Serial_in),
    .q     (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    active_d  = active_q;

    case (state_q)
      s_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = s_START;
      end

      // A start bit still low at its midpoint is real; anything else was a glitch.
      s_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = s_DATA;
          end else begin
            state_d = s_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      s_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d             = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = s_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      s_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s == STOP_LEVEL) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = s_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      s_CLEANUP: begin
        active_d = 1'b0;
        state_d  = s_IDLE;
      end

      s_WAIT_IDLE: begin
        active_d = 1'b0;
        if (rx_s) state_d = s_IDLE;
      end

      default: begin
        active_d = 1'b0;
        state_d  = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= s_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign Rx_DV_out        = dv_q;
  assign Rx_Byte_out      = byte_q;
  assign Rx_Active_out    = active_q;
  assign Rx_Frame_Err_out = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: a fast instance (8 clocks/bit) for framing
// behaviour and a full-rate instance (868 clocks/bit) for baud tolerance.
module tb_receiver;

  localparam int unsigned CPB_A = 8;
  localparam int unsigned CPB_B = 868;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic       dv_a, act_a, ferr_a, dv_b, act_b, ferr_b;
  logic [7:0] byte_a, byte_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  receiver #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .CLK(clk), .RST_N(rst_n), .Rx_Serial_in(rx_a), .Rx_DV_out(dv_a),
    .Rx_Byte_out(byte_a), .Rx_Active_out(act_a), .Rx_Frame_Err_out(ferr_a)
  );

  receiver #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .CLK(clk), .RST_N(rst_n), .Rx_Serial_in(rx_b), .Rx_DV_out(dv_b),
    .Rx_Byte_out(byte_b), .Rx_Active_out(act_b), .Rx_Frame_Err_out(ferr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation of instance A, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned dv_cnt_a = 0, ferr_cnt_a = 0, act_rise_a = 0;
  int unsigned both_hi = 0, long_pulse = 0, byte_glitch = 0;
  int unsigned last_dv_cyc = 0, last_fall_cyc = 0;
  logic [7:0]  got_q[$];
  logic        p_dv = 0, p_ferr = 0, p_act = 0;
  logic [7:0]  p_byte = 8'h00;
  int unsigned dv_cnt_b = 0, ferr_cnt_b = 0;
  logic [7:0]  got_b = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (dv_a) begin
        dv_cnt_a++;
        got_q.push_back(byte_a);
        last_dv_cyc = cyc;
      end
      if (ferr_a) ferr_cnt_a++;
      if (act_a && !p_act) act_rise_a++;
      if (!act_a && p_act) last_fall_cyc = cyc;
      if (dv_a && ferr_a) both_hi++;
      if ((dv_a && p_dv) || (ferr_a && p_ferr)) long_pulse++;
      if (byte_a !== p_byte && !dv_a) byte_glitch++;
      if (dv_b) begin
        dv_cnt_b++;
        got_b = byte_b;
      end
      if (ferr_b) ferr_cnt_b++;
    end
    p_dv = dv_a; p_ferr = ferr_a; p_act = act_a; p_byte = byte_a;
  end

  task automatic clear_obs();
    dv_cnt_a = 0; ferr_cnt_a = 0; act_rise_a = 0;
    got_q.delete();
    dv_cnt_b = 0; ferr_cnt_b = 0;
  endtask

  task automatic drive(input bit sel_b, input logic v);
    if (sel_b) rx_b = v; else rx_a = v;
  endtask

  // Line-level transmitter model: start, 8 data bits LSB first, stop.
  task automatic send_frame(input bit sel_b, input logic [7:0] data, input logic stop,
                            input int unsigned bit_clks);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(sel_b, bits[i]);
      repeat (bit_clks) @(negedge clk);
    end
    drive(sel_b, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dv_a, ferr_a, act_a, byte_a} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got dv=%b ferr=%b act=%b byte=%h want 0 0 0 00",
               dv_a, ferr_a, act_a, byte_a);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_obs();
  endtask

  task automatic test_single_frame();
    clear_obs();
    send_frame(1'b0, 8'hA5, 1'b1, CPB_A);
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (dv_cnt_a != 1) begin
      n_fail++; $display("FAIL single_dv_count got %0d want 1", dv_cnt_a);
    end
    n_checks++;
    if (byte_a !== 8'hA5) begin
      n_fail++; $display("FAIL single_byte got %h want a5", byte_a);
    end
    n_checks++;
    if (ferr_cnt_a != 0) begin
      n_fail++; $display("FAIL single_ferr got %0d want 0", ferr_cnt_a);
    end
    n_checks++;
    if (act_a !== 1'b0 || last_fall_cyc < last_dv_cyc || last_fall_cyc - last_dv_cyc > 2) begin
      n_fail++;
      $display("FAIL single_active_drop got act=%b gap=%0d want act=0 gap<=2",
               act_a, last_fall_cyc - last_dv_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
    clear_obs();
    foreach (exp_q[i]) send_frame(1'b0, exp_q[i], 1'b1, CPB_A);
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got %h want %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++;
    if (ferr_cnt_a != 0) begin
      n_fail++; $display("FAIL b2b_ferr got %0d want 0", ferr_cnt_a);
    end
  endtask

  task automatic test_glitch();
    int unsigned glen;
    glen = $urandom_range(1, 2);
    clear_obs();
    rx_a = 1'b0;
    repeat (glen) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (act_rise_a != 0 || dv_cnt_a != 0) begin
      n_fail++;
      $display("FAIL glitch_ignored got act_rises=%0d dv=%0d want 0 0 (len %0d)",
               act_rise_a, dv_cnt_a, glen);
    end
    send_frame(1'b0, 8'h5A, 1'b1, CPB_A);
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (dv_cnt_a != 1 || byte_a !== 8'h5A) begin
      n_fail++; $display("FAIL glitch_recover got dv=%0d byte=%h want 1 5a", dv_cnt_a, byte_a);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] prev;
    prev = byte_a;
    clear_obs();
    send_frame(1'b0, 8'h81, 1'b0, CPB_A);
    rx_a = 1'b0;
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (ferr_cnt_a != 1 || dv_cnt_a != 0 || act_rise_a != 1) begin
      n_fail++;
      $display("FAIL ferr_during_break got ferr=%0d dv=%0d act_rises=%0d want 1 0 1",
               ferr_cnt_a, dv_cnt_a, act_rise_a);
    end
    rx_a = 1'b1;
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (ferr_cnt_a != 1 || dv_cnt_a != 0 || byte_a !== prev) begin
      n_fail++;
      $display("FAIL ferr_after_break got ferr=%0d dv=%0d byte=%h want 1 0 %h",
               ferr_cnt_a, dv_cnt_a, byte_a, prev);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bits = {1'b1, 8'h77, 1'b0};
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      rx_a = bits[i];
      repeat (CPB_A) @(negedge clk);
    end
    rx_a = bits[5];
    repeat (CPB_A / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dv_a, ferr_a, act_a, byte_a} !== 11'h000) begin
      n_fail++;
      $display("FAIL midframe_reset got dv=%b ferr=%b act=%b byte=%h want 0 0 0 00",
               dv_a, ferr_a, act_a, byte_a);
    end
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB_A) @(negedge clk);
    n_checks++;
    if (dv_cnt_a != 0) begin
      n_fail++; $display("FAIL midframe_no_dv got %0d want 0", dv_cnt_a);
    end
    send_frame(1'b0, 8'h12, 1'b1, CPB_A);
    repeat (3 * CPB_A) @(negedge clk);
    n_checks++;
    if (dv_cnt_a != 1 || byte_a !== 8'h12) begin
      n_fail++; $display("FAIL post_reset_frame got dv=%0d byte=%h want 1 12", dv_cnt_a, byte_a);
    end
  endtask

  task automatic test_baud_tolerance();
    int unsigned periods[2];
    periods = '{CPB_B * 98 / 100, CPB_B * 102 / 100};
    foreach (periods[k]) begin
      clear_obs();
      send_frame(1'b1, 8'hC3, 1'b1, periods[k]);
      repeat (2 * CPB_B) @(negedge clk);
      n_checks++;
      if (dv_cnt_b != 1 || got_b !== 8'hC3 || ferr_cnt_b != 0) begin
        n_fail++;
        $display("FAIL baud_%0dclk got dv=%0d byte=%h ferr=%0d want 1 c3 0",
                 periods[k], dv_cnt_b, got_b, ferr_cnt_b);
      end
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (both_hi != 0 || long_pulse != 0) begin
      n_fail++; $display("FAIL pulse_rules got overlap=%0d long=%0d want 0 0", both_hi, long_pulse);
    end
    n_checks++;
    if (byte_glitch != 0) begin
      n_fail++; $display("FAIL byte_stable got %0d changes without DV want 0", byte_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_baud_tolerance();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
UART receiver core. It deserializes the UART line into 8-bit parallel bytes using the standard frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of the project's UART transmitter and shares its baud parameterization. It feeds received bytes, such as SHA-256 message blocks from the host, into the downstream datapath through a one-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 868, system clock cycles per UART bit (CLK frequency / baud rate); must be at least 4.
HALF_BIT (localparam), (CLKS_PER_BIT-1)/2, count at which the start-bit midpoint is checked.
CNT_W (localparam), $clog2(CLKS_PER_BIT)+1, width of the bit-period counter.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
Rx_Serial_in  input  1  asynchronous UART line; idles high.
Rx_DV_out  output  1  one-cycle pulse; Rx_Byte_out holds a newly received byte.
Rx_Byte_out  output  8  last correctly framed byte; held until the next valid byte.
Rx_Active_out  output  1  high from start-bit acceptance until the frame ends.
Rx_Frame_Err_out  output  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Clock and reset:
  - Single clock, CLK. Reset is asynchronous and active-low on RST_N; all flops use it.
  - Reset values: Rx_DV_out=0, Rx_Byte_out=8'h00, Rx_Active_out=0, Rx_Frame_Err_out=0, state=s_IDLE, counters=0, both synchronizer flops=1.
- Input synchronizer:
  - Rx_Serial_in passes through a 2-flop synchronizer before any use; the FSM sees only the synchronized bit (rx_s).
  - Every latency below is measured from rx_s.
- s_IDLE:
  - Counters are cleared.
  - rx_s==0 moves to s_START.
- s_START:
  - The counter increments each cycle.
  - At count==HALF_BIT: if rx_s==0, clear the counter, set Rx_Active_out=1 and go to s_DATA.
  - If rx_s==1 at that point, treat it as a glitch and return to s_IDLE; no outputs change.
- s_DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift register bit [Bit_Index] and clear the counter.
  - Each sample therefore lands at the centre of its data bit.
  - Bit_Index increments 0 to 7. After the sample at index 7, go to s_STOP and reset Bit_Index to 0.
- s_STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: on the next clock, Rx_Byte_out<=shift register and Rx_DV_out=1 for exactly one cycle; go to s_CLEANUP.
  - rx_s==0: Rx_Frame_Err_out=1 for one cycle, Rx_Byte_out unchanged, Rx_DV_out stays 0; go to s_WAIT_IDLE.
- s_CLEANUP:
  - One cycle; Rx_Active_out<=0; go to s_IDLE.
- s_WAIT_IDLE:
  - Rx_Active_out<=0.
  - Stay until rx_s==1, then go to s_IDLE. This prevents a held-low break from being decoded as repeated 0x00 frames.
- Pulse and output rules:
  - Rx_DV_out and Rx_Frame_Err_out are never high in the same cycle.
  - Neither is ever high for more than one cycle.
  - Rx_Byte_out changes only in the cycle Rx_DV_out rises.
- Back-to-back frames: a start edge immediately after the stop-bit sample is accepted. s_CLEANUP lasts one cycle, which leaves over half a bit of margin.
- Unused state encodings go to s_IDLE.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded and no DV is emitted.
- Counter and arithmetic rules:
  - Counter compares use CNT_W bits.
  - No wrap is possible, because the counter clears at CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg: state encodings s_IDLE, s_START, s_DATA, s_STOP, s_CLEANUP, s_WAIT_IDLE (3-bit), plus the UART frame constants DATA_BITS=8 and STOP_LEVEL=1'b1. The transmitter shares these constants.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with async active-low reset and reset value as a parameter (1 here).
- The FSM, counters and shift register stay in receiver.

Test Plan:
1. CLKS_PER_BIT=8; drive frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one Rx_DV_out pulse; Rx_Byte_out=8'hA5; Rx_Frame_Err_out stays 0; Rx_Active_out low again within 2 cycles of DV.
2. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three DV pulses, bytes in order 00, FF, 3C, no frame errors.
3. Low glitch of 2 cycles (less than HALF_BIT) on an idle line -> no Rx_Active_out, no DV; the next valid frame 0x5A is received correctly.
4. Frame 0x81 with the stop bit forced 0, line held low 3 bit-times, then high -> one Rx_Frame_Err_out pulse, no DV, Rx_Byte_out keeps its previous value, and no further events until the line returns high.
5. Assert RST_N=0 during data bit 4 of frame 0x77 -> outputs return to reset values asynchronously; after release, frame 0x12 yields DV with 8'h12.
6. Baud tolerance: CLKS_PER_BIT=868, transmitter model at a ±2% bit period sending 0xC3 -> byte received as 8'hC3 with no frame error.
